// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the SD sector-engine request arbiter.
package sd_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } arb_state_t;

    localparam int REQ_FDC_A = 0;
    localparam int REQ_FDC_B = 1;
    localparam int REQ_ACSI0 = 2;
    localparam int REQ_ACSI1 = 3;

    localparam int unsigned TO_CYCLES_DEF = 32'd16777216;

endpackage

// File: rtl/sd_req_arbiter_if.sv
// Requester-side and SD-engine-side signals of the sector arbiter.
// slave = arbiter view, master = requesters plus SD engine view.
interface sd_req_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0] req_rd;
    logic [NREQ-1:0] req_wr;
    logic [31:0]     req_lba [NREQ];
    logic [NREQ-1:0] req_busy;
    logic [NREQ-1:0] req_done;
    logic [NREQ-1:0] req_err;
    logic            sd_rd;
    logic            sd_wr;
    logic [31:0]     sd_lba;
    logic [2:0]      sd_img;
    logic            sd_busy;
    logic            sd_done;

    modport slave (
        input  req_rd, req_wr, req_lba, sd_busy, sd_done,
        output req_busy, req_done, req_err, sd_rd, sd_wr, sd_lba, sd_img
    );

    modport master (
        output req_rd, req_wr, req_lba, sd_busy, sd_done,
        input  req_busy, req_done, req_err, sd_rd, sd_wr, sd_lba, sd_img
    );
endinterface

// File: rtl/sd_req_arbiter_rr_pick.sv
// Combinational round-robin encoder: first set bit of pend searching from last+1 with wrap.
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] pend,
    input  logic [2:0]      last,
    output logic            valid,
    output logic [2:0]      idx
);
    // distance of requester i behind the last grant; the smallest set distance wins
    function automatic logic [3:0] rr_dist(input int i, input logic [2:0] l);
        return 4'((i + 2 * NREQ - int'(l) - 1) % NREQ);
    endfunction

    logic [3:0] best_d;

    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        best_d = 4'(NREQ);
        for (int i = 0; i < NREQ; i++) begin
            if (pend[i] && (rr_dist(i, last) < best_d)) begin
                best_d = rr_dist(i, last);
                idx    = 3'(i);
                valid  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sd_req_arbiter.sv
// Round-robin arbiter sharing one SD sector engine between NREQ requesters.
// Optional watchdog abort is built when SD_ARB_TIMEOUT_EN is defined.
//
// state    | meaning
// ST_IDLE  | no transaction; grant next pending requester
// ST_ISSUE | rd/wr strobe held toward SD engine, waiting for sd_busy
// ST_BUSY  | engine accepted the sector, waiting for sd_done
import sd_arb_pkg::*;

module sd_req_arbiter #(
    parameter int          NREQ      = 4,
    parameter int unsigned TO_CYCLES = TO_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    sd_req_arbiter_if.slave bus
);
    arb_state_t      state;
    logic [2:0]      g;
    logic [2:0]      last;
    logic            sd_rd_q;
    logic            sd_wr_q;
    logic [31:0]     sd_lba_q;
    logic [NREQ-1:0] busy_q;
    logic [NREQ-1:0] done_q;

    logic            pick_valid;
    logic [2:0]      pick_idx;
    logic [31:0]     lba_sel;
    logic            rd_sel;
    logic [NREQ-1:0] g_oh;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .pend  (bus.req_rd | bus.req_wr),
        .last  (last),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        lba_sel = '0;
        rd_sel  = 1'b0;
        g_oh    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == 3'(i)) begin
                lba_sel = bus.req_lba[i];
                rd_sel  = bus.req_rd[i];
            end
            g_oh[i] = (g == 3'(i));
        end
    end

`ifdef SD_ARB_TIMEOUT_EN
    localparam int            TW      = $clog2(TO_CYCLES + 1);
    localparam logic [TW-1:0] TO_LOAD = TW'(TO_CYCLES - 1);

    logic [TW-1:0]   to_cnt;
    logic            to_hit;
    logic            timer_start;
    logic [NREQ-1:0] err_q;

    assign timer_start = ((state == ST_IDLE) && pick_valid) ||
                         ((state == ST_ISSUE) && bus.sd_busy && !bus.sd_done);

    // down-counter; reaching zero while ISSUE/BUSY means TO_CYCLES elapsed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt <= '0;
        end else if (timer_start) begin
            to_cnt <= TO_LOAD;
        end else if (to_cnt != '0) begin
            to_cnt <= to_cnt - 1'b1;
        end
    end

    assign to_hit      = (to_cnt == '0);
    assign bus.req_err = err_q;
`else
    logic unused_to_cycles;
    assign unused_to_cycles = ^TO_CYCLES;
    assign bus.req_err      = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            g        <= '0;
            last     <= 3'(NREQ - 1);
            sd_rd_q  <= 1'b0;
            sd_wr_q  <= 1'b0;
            sd_lba_q <= '0;
            busy_q   <= '0;
            done_q   <= '0;
`ifdef SD_ARB_TIMEOUT_EN
            err_q    <= '0;
`endif
        end else begin
            busy_q <= '0;
            done_q <= '0;
`ifdef SD_ARB_TIMEOUT_EN
            err_q  <= '0;
`endif
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        g        <= pick_idx;
                        last     <= pick_idx;
                        sd_lba_q <= lba_sel;
                        sd_rd_q  <= rd_sel;
                        sd_wr_q  <= !rd_sel;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.sd_busy) begin
                        sd_rd_q <= 1'b0;
                        sd_wr_q <= 1'b0;
                        busy_q  <= g_oh;
                        if (bus.sd_done) begin
                            done_q <= g_oh;
                            state  <= ST_IDLE;
                        end else begin
                            state  <= ST_BUSY;
                        end
                    end
`ifdef SD_ARB_TIMEOUT_EN
                    else if (to_hit) begin
                        sd_rd_q <= 1'b0;
                        sd_wr_q <= 1'b0;
                        done_q  <= g_oh;
                        err_q   <= g_oh;
                        state   <= ST_IDLE;
                    end
`endif
                end
                ST_BUSY: begin
                    if (bus.sd_done) begin
                        done_q <= g_oh;
                        state  <= ST_IDLE;
                    end
`ifdef SD_ARB_TIMEOUT_EN
                    else if (to_hit) begin
                        done_q <= g_oh;
                        err_q  <= g_oh;
                        state  <= ST_IDLE;
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.sd_rd    = sd_rd_q;
    assign bus.sd_wr    = sd_wr_q;
    assign bus.sd_lba   = sd_lba_q;
    assign bus.sd_img   = g;
    assign bus.req_busy = busy_q;
    assign bus.req_done = done_q;
endmodule

// File: tb/tb_sd_req_arbiter.sv
// Self-checking bench for sd_req_arbiter: directed cases plus random traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_sd_req_arbiter;
    import sd_arb_pkg::*;

    localparam int NREQ = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sd_req_arbiter_if #(.NREQ(NREQ)) bus();

    sd_req_arbiter #(.NREQ(NREQ), .TO_CYCLES(100)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // transaction model: who owns the engine, whether it has accepted, what was captured
    int              m_owner;
    int              m_last;
    bit              m_ack;
    bit              m_dir_rd;
    logic [31:0]     m_lba;
    logic [2:0]      m_img;
    logic [NREQ-1:0] m_busy;
    logic [NREQ-1:0] m_done;

    function automatic int rr_next(input logic [NREQ-1:0] pend, input int lst);
        for (int k = 1; k <= NREQ; k++) begin
            if (pend[(lst + k) % NREQ]) return (lst + k) % NREQ;
        end
        return -1;
    endfunction

    int nxt_g;
    always_comb nxt_g = rr_next(bus.req_rd | bus.req_wr, m_last);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_owner  <= -1;
            m_last   <= NREQ - 1;
            m_ack    <= 1'b0;
            m_dir_rd <= 1'b0;
            m_lba    <= '0;
            m_img    <= '0;
            m_busy   <= '0;
            m_done   <= '0;
        end else begin
            m_busy <= '0;
            m_done <= '0;
            if (m_owner < 0) begin
                if (nxt_g >= 0) begin
                    m_owner  <= nxt_g;
                    m_last   <= nxt_g;
                    m_ack    <= 1'b0;
                    m_dir_rd <= bus.req_rd[nxt_g];
                    m_lba    <= bus.req_lba[nxt_g];
                    m_img    <= 3'(nxt_g);
                end
            end else if (!m_ack) begin
                if (bus.sd_busy) begin
                    m_busy <= NREQ'(1) << m_owner;
                    if (bus.sd_done) begin
                        m_done  <= NREQ'(1) << m_owner;
                        m_owner <= -1;
                    end else begin
                        m_ack <= 1'b1;
                    end
                end
            end else if (bus.sd_done) begin
                m_done  <= NREQ'(1) << m_owner;
                m_owner <= -1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("sd_rd",    32'(bus.sd_rd),    32'(m_owner >= 0 && !m_ack && m_dir_rd));
            chk("sd_wr",    32'(bus.sd_wr),    32'(m_owner >= 0 && !m_ack && !m_dir_rd));
            chk("sd_lba",   bus.sd_lba,        m_lba);
            chk("sd_img",   32'(bus.sd_img),   32'(m_img));
            chk("req_busy", 32'(bus.req_busy), 32'(m_busy));
            chk("req_done", 32'(bus.req_done), 32'(m_done));
            chk("req_err",  32'(bus.req_err),  32'd0);
        end
    end

    task automatic wait_strobe(input string name);
        bit ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.sd_rd || bus.sd_wr) begin
                ok = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: no sd_rd/sd_wr within 20 cycles", name);
        end
    endtask

    task automatic sd_accept_then_done(input int req, input bit drop_rd);
        bus.sd_busy = 1'b1;
        @(negedge clk);
        bus.sd_busy = 1'b0;
        if (drop_rd) bus.req_rd[req] = 1'b0;
        else         bus.req_wr[req] = 1'b0;
        @(negedge clk);
        bus.sd_done = 1'b1;
        @(negedge clk);
        bus.sd_done = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    int r;
    int order_exp [5] = '{0, 1, 2, 3, 0};

    initial begin
        bus.req_rd  = '0;
        bus.req_wr  = '0;
        bus.sd_busy = 1'b0;
        bus.sd_done = 1'b0;
        for (int i = 0; i < NREQ; i++) bus.req_lba[i] = '0;

        chk("model_rr_wrap",  32'(rr_next(4'b1111, 3)), 32'd0);
        chk("model_rr_skip",  32'(rr_next(4'b1010, 1)), 32'd3);
        chk("model_rr_wrap2", 32'(rr_next(4'b0110, 2)), 32'd1);
        chk("model_rr_none",  32'(rr_next(4'b0000, 0)), 32'hFFFF_FFFF);

        repeat (3) @(negedge clk);
        chk("rst_strobes", {30'd0, bus.sd_rd, bus.sd_wr}, 32'd0);
        chk("rst_pulses",  {20'd0, bus.req_busy, bus.req_done, bus.req_err}, 32'd0);
        chk("rst_lba_img", bus.sd_lba | 32'(bus.sd_img), 32'd0);
        reset_n = 1'b1;
        cmp_en  = 1'b1;

        // single read from ACSI0
        @(negedge clk);
        bus.req_lba[REQ_ACSI0] = 32'h1234;
        bus.req_rd[REQ_ACSI0]  = 1'b1;
        @(negedge clk);
        chk("t1_sd_rd",  32'(bus.sd_rd),  32'd1);
        chk("t1_sd_img", 32'(bus.sd_img), 32'd2);
        chk("t1_sd_lba", bus.sd_lba,      32'h1234);
        bus.sd_busy = 1'b1;
        @(negedge clk);
        bus.sd_busy = 1'b0;
        bus.req_rd[REQ_ACSI0] = 1'b0;
        chk("t1_req_busy", 32'(bus.req_busy), 32'b0100);
        chk("t1_rd_drop",  32'(bus.sd_rd),    32'd0);
        @(negedge clk);
        chk("t1_busy_once", 32'(bus.req_busy), 32'd0);
        bus.sd_done = 1'b1;
        @(negedge clk);
        bus.sd_done = 1'b0;
        chk("t1_req_done", 32'(bus.req_done), 32'b0100);
        @(negedge clk);
        chk("t1_done_once", 32'(bus.req_done), 32'd0);

        // reset asserted while BUSY; a later sd_done must not surface
        bus.req_lba[REQ_ACSI1] = 32'hDEAD_BEEF;
        bus.req_rd[REQ_ACSI1]  = 1'b1;
        wait_strobe("rst_mid_grant");
        bus.sd_busy = 1'b1;
        @(negedge clk);
        bus.sd_busy = 1'b0;
        bus.req_rd[REQ_ACSI1] = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_lba", bus.sd_lba, 32'd0);
        chk("rst_mid_img", 32'(bus.sd_img), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        bus.sd_done = 1'b1;
        @(negedge clk);
        bus.sd_done = 1'b0;
        chk("rst_stray_done", 32'(bus.req_done), 32'd0);
        @(negedge clk);
        chk("rst_stray_done2", 32'(bus.req_done), 32'd0);

        // all four read continuously: grants rotate from 0
        bus.req_rd = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            wait_strobe("rr_grant");
            chk("rr_order", 32'(bus.sd_img), 32'(order_exp[t]));
            bus.sd_busy = 1'b1;
            @(negedge clk);
            bus.sd_busy = 1'b0;
            @(negedge clk);
            bus.sd_done = 1'b1;
            @(negedge clk);
            bus.sd_done = 1'b0;
            if (t == 4) bus.req_rd = '0;
        end

        // read and write both pending on FDC_B: read first, then write
        bus.req_rd[REQ_FDC_B] = 1'b1;
        bus.req_wr[REQ_FDC_B] = 1'b1;
        wait_strobe("rw_first");
        chk("rw_first_rd",  32'(bus.sd_rd),  32'd1);
        chk("rw_first_wr",  32'(bus.sd_wr),  32'd0);
        chk("rw_first_img", 32'(bus.sd_img), 32'd1);
        sd_accept_then_done(REQ_FDC_B, 1'b1);
        wait_strobe("rw_second");
        chk("rw_second_wr",  32'(bus.sd_wr),  32'd1);
        chk("rw_second_rd",  32'(bus.sd_rd),  32'd0);
        chk("rw_second_img", 32'(bus.sd_img), 32'd1);
        sd_accept_then_done(REQ_FDC_B, 1'b0);

        // sd_busy and sd_done together while issuing
        bus.req_rd[REQ_FDC_A] = 1'b1;
        wait_strobe("bd_grant");
        bus.sd_busy = 1'b1;
        bus.sd_done = 1'b1;
        @(negedge clk);
        bus.sd_busy = 1'b0;
        bus.sd_done = 1'b0;
        bus.req_rd[REQ_FDC_A] = 1'b0;
        chk("bd_busy",  32'(bus.req_busy), 32'b0001);
        chk("bd_done",  32'(bus.req_done), 32'b0001);
        chk("bd_rd",    32'(bus.sd_rd),    32'd0);
        bus.req_rd[REQ_ACSI0] = 1'b1;
        @(negedge clk);
        chk("bd_idle_regrant", 32'(bus.sd_rd),  32'd1);
        chk("bd_idle_img",     32'(bus.sd_img), 32'd2);
        sd_accept_then_done(REQ_ACSI0, 1'b1);

`ifdef SD_ARB_TIMEOUT_EN
        bus.req_rd[REQ_FDC_A] = 1'b1;
        wait_strobe("to_grant");
        cmp_en = 1'b0;
        begin
            int c;
            for (c = 1; c <= 200; c++) begin
                @(negedge clk);
                if (bus.req_done != '0) break;
            end
            bus.req_rd[REQ_FDC_A] = 1'b0;
            chk("to_cycles", 32'(c), 32'd100);
            chk("to_done", 32'(bus.req_done), 32'b0001);
            chk("to_err",  32'(bus.req_err),  32'b0001);
            chk("to_rd",   32'(bus.sd_rd),    32'd0);
        end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        cmp_en  = 1'b1;
`endif

        // random traffic; requesters only drop a request when not owning the engine
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_busy[i]) begin
                    if (bus.req_rd[i]) bus.req_rd[i] = 1'b0;
                    else               bus.req_wr[i] = 1'b0;
                end else if (m_owner != i) begin
                    r = $urandom_range(0, 15);
                    if (r == 0)      bus.req_rd[i] = 1'b1;
                    else if (r == 1) bus.req_wr[i] = 1'b1;
                    else if (r == 2) begin
                        bus.req_rd[i] = 1'b0;
                        bus.req_wr[i] = 1'b0;
                    end
                    if (!bus.req_rd[i] && !bus.req_wr[i]) bus.req_lba[i] = $urandom;
                end
            end
            bus.sd_busy = ($urandom_range(0, 3) == 0);
            bus.sd_done = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        bus.sd_busy = 1'b0;
        bus.sd_done = 1'b0;
        @(negedge clk);
        cmp_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
